// File: rtl/hangman_host_display_param.sv
// Host-side Hangman display engine: tracks reveals, mistakes and win/lose, drives two ASCII LCD rows.
// Optional build macro DUP_FILTER_EN: discard mistakes whose letter is already in the history.
module hangman_host_display_param #(
    parameter int WORD_LEN     = 5,
    parameter int MAX_MISTAKES = 6,
    parameter int ROW_CHARS    = 16,
    parameter int HOLD_CYCLES  = 1000
) (
    input  logic                                clk,
    input  logic                                nRst,
    input  logic                                guess_valid,
    input  logic [7:0]                          letter,
    input  logic [WORD_LEN-1:0]                 index_correct,
    input  logic                                mistake,
    input  logic [8*WORD_LEN-1:0]               word,
    input  logic                                new_game,
    output logic [8*ROW_CHARS-1:0]              top,
    output logic [8*ROW_CHARS-1:0]              bottom,
    output logic [1:0]                          game_state,
    output logic [$clog2(MAX_MISTAKES+1)-1:0]   mistake_cnt
);

    localparam int CW = $clog2(MAX_MISTAKES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned WPAD = (ROW_CHARS - WORD_LEN) / 2;
    localparam int unsigned MPAD = (ROW_CHARS - MAX_MISTAKES) / 2;
    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] US = 8'h5F;
    localparam logic [CW-1:0] MAXC = CW'(MAX_MISTAKES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        PLAY = 2'b00,
        WIN  = 2'b01,
        LOSE = 2'b10
    } state_t;

    function automatic logic [8*ROW_CHARS-1:0] put(input logic [8*ROW_CHARS-1:0] row,
                                                   input int unsigned pos,
                                                   input logic [7:0] ch);
        row[8*(ROW_CHARS-1-pos) +: 8] = ch;
        return row;
    endfunction

    // Slot b of the word (bit b of index_correct) sits at column WPAD + WORD_LEN-1-b.
    function automatic logic [8*ROW_CHARS-1:0] play_top(input logic [WORD_LEN-1:0] rev,
                                                        input logic [8*WORD_LEN-1:0] slots);
        logic [8*ROW_CHARS-1:0] r;
        r = {ROW_CHARS{SP}};
        for (int unsigned b = 0; b < WORD_LEN; b++)
            r = put(r, WPAD + WORD_LEN - 1 - b, rev[b] ? slots[8*b +: 8] : US);
        return r;
    endfunction

    function automatic logic [8*ROW_CHARS-1:0] play_bottom(input logic [8*MAX_MISTAKES-1:0] hist);
        logic [8*ROW_CHARS-1:0] r;
        r = {ROW_CHARS{SP}};
        for (int unsigned h = 0; h < MAX_MISTAKES; h++)
            r = put(r, MPAD + h, hist[8*h +: 8]);
        return r;
    endfunction

    function automatic logic [8*ROW_CHARS-1:0] word_row(input logic [8*WORD_LEN-1:0] w);
        logic [8*ROW_CHARS-1:0] r;
        r = {ROW_CHARS{SP}};
        for (int unsigned b = 0; b < WORD_LEN; b++)
            r = put(r, WPAD + WORD_LEN - 1 - b, w[8*b +: 8]);
        return r;
    endfunction

    function automatic logic [8*ROW_CHARS-1:0] msg_row(input logic [31:0] txt,
                                                       input int unsigned len);
        logic [8*ROW_CHARS-1:0] r;
        r = {ROW_CHARS{SP}};
        for (int unsigned i = 0; i < len; i++)
            r = put(r, (ROW_CHARS - len) / 2 + i, txt[8*(len-1-i) +: 8]);
        return r;
    endfunction

    localparam logic [8*ROW_CHARS-1:0] EMPTY_TOP    = play_top('0, '0);
    localparam logic [8*MAX_MISTAKES-1:0] HIST_CLR  = {MAX_MISTAKES{US}};
    localparam logic [8*ROW_CHARS-1:0] EMPTY_BOTTOM = play_bottom(HIST_CLR);

    state_t                    state_q, state_d;
    logic [WORD_LEN-1:0]       rev_q, rev_d;
    logic [8*WORD_LEN-1:0]     slots_q, slots_d;
    logic [8*MAX_MISTAKES-1:0] hist_q, hist_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [HW-1:0]             hold_q, hold_d;
    logic                      dup_hit;
    logic [8*ROW_CHARS-1:0]    top_d, bottom_d;

`ifdef DUP_FILTER_EN
    // Only filled history slots count; empty ones still hold '_'.
    always_comb begin
        dup_hit = 1'b0;
        for (int unsigned j = 0; j < MAX_MISTAKES; j++)
            if (j < 32'(cnt_q) && hist_q[8*j +: 8] == letter)
                dup_hit = 1'b1;
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= PLAY;
            rev_q   <= '0;
            slots_q <= '0;
            hist_q  <= HIST_CLR;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            rev_q   <= rev_d;
            slots_q <= slots_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rev_d   = rev_q;
        slots_d = slots_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        if (new_game) begin
            state_d = PLAY;
            rev_d   = '0;
            hist_d  = HIST_CLR;
            cnt_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (guess_valid && mistake) begin
                        if (!dup_hit && cnt_q < MAXC) begin
                            for (int unsigned j = 0; j < MAX_MISTAKES; j++)
                                if (j == 32'(cnt_q))
                                    hist_d[8*j +: 8] = letter;
                            cnt_d = cnt_q + CW'(1);
                            if (cnt_d == MAXC) begin
                                state_d = LOSE;
                                hold_d  = HOLD_LOAD;
                            end
                        end
                    end else if (guess_valid) begin
                        for (int unsigned b = 0; b < WORD_LEN; b++)
                            if (index_correct[b] && !rev_q[b])
                                slots_d[8*b +: 8] = letter;
                        rev_d = rev_q | index_correct;
                        if (&rev_d) begin
                            state_d = WIN;
                            hold_d  = HOLD_LOAD;
                        end
                    end
                end
                WIN, LOSE: begin
                    if (hold_q == '0) begin
                        state_d = PLAY;
                        rev_d   = '0;
                        hist_d  = HIST_CLR;
                        cnt_d   = '0;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: state_d = PLAY;
            endcase
        end
    end

    // Display rows are rendered from the committed state, giving one cycle of output latency.
    always_comb begin
        top_d    = play_top(rev_q, slots_q);
        bottom_d = play_bottom(hist_q);
        case (state_q)
            WIN: begin
                top_d    = msg_row(32'h0057696E, 3);
                bottom_d = word_row(word);
            end
            LOSE: begin
                top_d    = msg_row(32'h4C6F7365, 4);
                bottom_d = word_row(word);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            top         <= EMPTY_TOP;
            bottom      <= EMPTY_BOTTOM;
            game_state  <= PLAY;
            mistake_cnt <= '0;
        end else begin
            top         <= top_d;
            bottom      <= bottom_d;
            game_state  <= state_q;
            mistake_cnt <= cnt_q;
        end
    end

endmodule

// File: tb/tb_hangman_host_display_param.sv
// Scoreboard bench for hangman_host_display_param (WORD_LEN=5, MAX_MISTAKES=6, ROW_CHARS=16, HOLD_CYCLES=4).
module tb_hangman_host_display_param;

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic         guess_valid = 1'b0;
    logic [7:0]   letter = '0;
    logic [4:0]   index_correct = '0;
    logic         mistake = 1'b0;
    logic [39:0]  word = 40'h48454C4C4F;
    logic         new_game = 1'b0;
    logic [127:0] top, bottom;
    logic [1:0]   game_state;
    logic [2:0]   mistake_cnt;

    typedef struct {
        string        name;
        logic [127:0] t;
        logic [127:0] b;
        logic [1:0]   gs;
        logic [2:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    hangman_host_display_param #(
        .WORD_LEN(5), .MAX_MISTAKES(6), .ROW_CHARS(16), .HOLD_CYCLES(4)
    ) dut (
        .clk(clk), .nRst(nRst), .guess_valid(guess_valid), .letter(letter),
        .index_correct(index_correct), .mistake(mistake), .word(word),
        .new_game(new_game), .top(top), .bottom(bottom),
        .game_state(game_state), .mistake_cnt(mistake_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] row(input string s);
        logic [127:0] r;
        int lp;
        r  = {16{8'h20}};
        lp = (16 - s.len()) / 2;
        for (int i = 0; i < s.len(); i++)
            r[8*(15-lp-i) +: 8] = s[i];
        return r;
    endfunction

    function automatic exp_t mk(input string n, input string t, input string b,
                                input logic [1:0] gs, input logic [2:0] cnt);
        exp_t e;
        e.name = n; e.t = row(t); e.b = row(b); e.gs = gs; e.cnt = cnt;
        return e;
    endfunction

    // Drive one strobe for one cycle, then wait until its effect is on the registered outputs.
    task automatic strobe(input logic [7:0] l, input logic [4:0] ic, input logic m,
                          input logic gv, input logic ng);
        letter = l; index_correct = ic; mistake = m; guess_valid = gv; new_game = ng;
        @(negedge clk);
        guess_valid = 1'b0; new_game = 1'b0; mistake = 1'b0; index_correct = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        sb.push_back(mk("reset", "_____", "______", 2'b00, 3'd0));
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        e = sb.pop_front();
        n_asrt++; if (top !== e.t) begin n_fail++; $display("FAIL %s.top got=%h want=%h", e.name, top, e.t); end
        n_asrt++; if (bottom !== e.b) begin n_fail++; $display("FAIL %s.bottom got=%h want=%h", e.name, bottom, e.b); end
        n_asrt++; if (game_state !== e.gs) begin n_fail++; $display("FAIL %s.state got=%b want=%b", e.name, game_state, e.gs); end
        n_asrt++; if (mistake_cnt !== e.cnt) begin n_fail++; $display("FAIL %s.cnt got=%0d want=%0d", e.name, mistake_cnt, e.cnt); end
    endtask

    task automatic test_reveal();
        exp_t e;
        logic [7:0] lt[3] = '{8'h4C, 8'h4C, 8'h58};
        logic [4:0] ic[3] = '{5'b00110, 5'b00110, 5'b00000};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk($sformatf("reveal%0d", i), "__LL_", "______", 2'b00, 3'd0));
            strobe(lt[i], ic[i], 1'b0, 1'b1, 1'b0);
            e = sb.pop_front();
            n_asrt++; if (top !== e.t) begin n_fail++; $display("FAIL %s.top got=%h want=%h", e.name, top, e.t); end
            n_asrt++; if (bottom !== e.b) begin n_fail++; $display("FAIL %s.bottom got=%h want=%h", e.name, bottom, e.b); end
            n_asrt++; if (game_state !== e.gs) begin n_fail++; $display("FAIL %s.state got=%b want=%b", e.name, game_state, e.gs); end
            n_asrt++; if (mistake_cnt !== e.cnt) begin n_fail++; $display("FAIL %s.cnt got=%0d want=%0d", e.name, mistake_cnt, e.cnt); end
        end
    endtask

    task automatic test_lose();
        exp_t  e;
        string s = "ABCDEF";
        string f;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                f = "______";
                for (int j = 0; j <= i; j++) f[j] = s[j];
                if (i < 5) sb.push_back(mk($sformatf("miss%0d", i), "__LL_", f, 2'b00, 3'(i + 1)));
                else       sb.push_back(mk("lose", "Lose", "HELLO", 2'b10, 3'd6));
                strobe(s[i], 5'b11111, 1'b1, 1'b1, 1'b0);
            end else begin
                // Guesses during the hold must be ignored; drop them before the expiry edge.
                if (i < 9) sb.push_back(mk($sformatf("lose_hold%0d", i - 5), "Lose", "HELLO", 2'b10, 3'd6));
                else       sb.push_back(mk("lose_expire", "_____", "______", 2'b00, 3'd0));
                guess_valid = (i < 9); letter = 8'h51; index_correct = 5'b11111;
                @(negedge clk);
                guess_valid = 1'b0; index_correct = '0;
            end
            e = sb.pop_front();
            n_asrt++; if (top !== e.t) begin n_fail++; $display("FAIL %s.top got=%h want=%h", e.name, top, e.t); end
            n_asrt++; if (bottom !== e.b) begin n_fail++; $display("FAIL %s.bottom got=%h want=%h", e.name, bottom, e.b); end
            n_asrt++; if (game_state !== e.gs) begin n_fail++; $display("FAIL %s.state got=%b want=%b", e.name, game_state, e.gs); end
            n_asrt++; if (mistake_cnt !== e.cnt) begin n_fail++; $display("FAIL %s.cnt got=%0d want=%0d", e.name, mistake_cnt, e.cnt); end
        end
    endtask

    task automatic test_win();
        exp_t  e;
        string lt = "HELO";
        string tops[3] = '{"H____", "HE___", "HELL_"};
        logic [4:0] ic[4] = '{5'b10000, 5'b01000, 5'b00110, 5'b00001};
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                if (i < 3) sb.push_back(mk($sformatf("win_step%0d", i), tops[i], "______", 2'b00, 3'd0));
                else       sb.push_back(mk("win", "Win", "HELLO", 2'b01, 3'd0));
                strobe(lt[i], ic[i], 1'b0, 1'b1, 1'b0);
            end else begin
                // Word is live during the hold: a change shows on the next edge.
                if (i == 5) word = 40'h574F524C44;
                if (i == 4)      sb.push_back(mk("win_hold1", "Win", "HELLO", 2'b01, 3'd0));
                else if (i < 7)  sb.push_back(mk($sformatf("win_hold%0d", i - 3), "Win", "WORLD", 2'b01, 3'd0));
                else             sb.push_back(mk("win_expire", "_____", "______", 2'b00, 3'd0));
                @(negedge clk);
            end
            e = sb.pop_front();
            n_asrt++; if (top !== e.t) begin n_fail++; $display("FAIL %s.top got=%h want=%h", e.name, top, e.t); end
            n_asrt++; if (bottom !== e.b) begin n_fail++; $display("FAIL %s.bottom got=%h want=%h", e.name, bottom, e.b); end
            n_asrt++; if (game_state !== e.gs) begin n_fail++; $display("FAIL %s.state got=%b want=%b", e.name, game_state, e.gs); end
            n_asrt++; if (mistake_cnt !== e.cnt) begin n_fail++; $display("FAIL %s.cnt got=%0d want=%0d", e.name, mistake_cnt, e.cnt); end
        end
        word = 40'h48454C4C4F;
    endtask

    task automatic test_new_game_priority();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                sb.push_back(mk("ng_pre", "H____", "______", 2'b00, 3'd0));
                strobe(8'h48, 5'b10000, 1'b0, 1'b1, 1'b0);
            end else begin
                sb.push_back(mk("ng_drop", "_____", "______", 2'b00, 3'd0));
                strobe(8'h48, 5'b10000, 1'b0, 1'b1, 1'b1);
            end
            e = sb.pop_front();
            n_asrt++; if (top !== e.t) begin n_fail++; $display("FAIL %s.top got=%h want=%h", e.name, top, e.t); end
            n_asrt++; if (bottom !== e.b) begin n_fail++; $display("FAIL %s.bottom got=%h want=%h", e.name, bottom, e.b); end
            n_asrt++; if (game_state !== e.gs) begin n_fail++; $display("FAIL %s.state got=%b want=%b", e.name, game_state, e.gs); end
            n_asrt++; if (mistake_cnt !== e.cnt) begin n_fail++; $display("FAIL %s.cnt got=%0d want=%0d", e.name, mistake_cnt, e.cnt); end
        end
    endtask

    task automatic test_dup();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) sb.push_back(mk("dup_first", "_____", "Z_____", 2'b00, 3'd1));
`ifdef DUP_FILTER_EN
            else        sb.push_back(mk("dup_second", "_____", "Z_____", 2'b00, 3'd1));
`else
            else        sb.push_back(mk("dup_second", "_____", "ZZ____", 2'b00, 3'd2));
`endif
            strobe(8'h5A, 5'b00000, 1'b1, 1'b1, 1'b0);
            e = sb.pop_front();
            n_asrt++; if (top !== e.t) begin n_fail++; $display("FAIL %s.top got=%h want=%h", e.name, top, e.t); end
            n_asrt++; if (bottom !== e.b) begin n_fail++; $display("FAIL %s.bottom got=%h want=%h", e.name, bottom, e.b); end
            n_asrt++; if (game_state !== e.gs) begin n_fail++; $display("FAIL %s.state got=%b want=%b", e.name, game_state, e.gs); end
            n_asrt++; if (mistake_cnt !== e.cnt) begin n_fail++; $display("FAIL %s.cnt got=%0d want=%0d", e.name, mistake_cnt, e.cnt); end
        end
    endtask

    task automatic test_async_reset();
        exp_t  e;
        string s = "GHIJKL";
        strobe(8'h00, 5'b00000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) strobe(s[i], 5'b00000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) sb.push_back(mk("pre_rst", "Lose", "HELLO", 2'b10, 3'd6));
            else        sb.push_back(mk($sformatf("async_rst%0d", i), "_____", "______", 2'b00, 3'd0));
            if (i == 1) begin
                #2 nRst = 1'b0;
                #1;
            end else if (i == 2) begin
                @(negedge clk); nRst = 1'b1;
                repeat (2) @(negedge clk);
            end
            e = sb.pop_front();
            n_asrt++; if (top !== e.t) begin n_fail++; $display("FAIL %s.top got=%h want=%h", e.name, top, e.t); end
            n_asrt++; if (bottom !== e.b) begin n_fail++; $display("FAIL %s.bottom got=%h want=%h", e.name, bottom, e.b); end
            n_asrt++; if (game_state !== e.gs) begin n_fail++; $display("FAIL %s.state got=%b want=%b", e.name, game_state, e.gs); end
            n_asrt++; if (mistake_cnt !== e.cnt) begin n_fail++; $display("FAIL %s.cnt got=%0d want=%0d", e.name, mistake_cnt, e.cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_reveal();
        test_lose();
        test_win();
        test_new_game_priority();
        test_dup();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
